// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;
  localparam logic [1:0] LSU_SZ_B = 2'b00;
  localparam logic [1:0] LSU_SZ_H = 2'b01;
  localparam logic [1:0] LSU_SZ_W = 2'b10;

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} lsu_state_e;

  // Illegal size is folded into misalignment so both take the error path.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      LSU_SZ_B: return 1'b0;
      LSU_SZ_H: return off[0];
      LSU_SZ_W: return off != 2'b00;
      default:  return 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [15:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] ld_o,
  output logic [31:0] merged_o
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b        = word_i[{off_i, 3'b000} +: 8];
    h        = off_i[1] ? word_i[31:16] : word_i[15:0];
    ld_o     = word_i;
    merged_o = word_i;
    case (size_i)
      LSU_SZ_B: begin
        ld_o = {{24{b[7] & ~uns_i}}, b};
        merged_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      LSU_SZ_H: begin
        ld_o = {{16{h[15] & ~uns_i}}, h};
        if (off_i[1]) merged_o[31:16] = wdata_i;
        else          merged_o[15:0]  = wdata_i;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store requester for a word-addressed synchronous data memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              lsu_clk,
  input  logic              lsu_rst,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_req_we,
  input  logic [1:0]        lsu_req_size,
  input  logic              lsu_req_unsigned,
  input  logic [AWIDTH-1:0] lsu_req_addr,
  input  logic [DWIDTH-1:0] lsu_req_wdata,
  output logic              lsu_rsp_valid,
  output logic [DWIDTH-1:0] lsu_rsp_rdata,
  output logic              lsu_rsp_err,
  output logic              dm_re,
  output logic              dm_we,
  output logic [AWIDTH-1:0] dm_addr,
  output logic [DWIDTH-1:0] dm_data_in,
  input  logic [DWIDTH-1:0] dm_data_out
);
  lsu_state_e        state_q, state_d;
  logic              we_q, uns_q, err_q;
  logic [1:0]        size_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] data_q, rdata_q;
  logic [31:0]       lane_ld, lane_merged;
  logic              accept;

  assign accept = (state_q == IDLE) && lsu_req_valid;

  // data_q holds store data until CAP, then the merged word for WR.
  lsu_byte_lane u_lane (
    .word_i   (dm_data_out),
    .wdata_i  (data_q[15:0]),
    .off_i    (addr_q[1:0]),
    .size_i   (size_q),
    .uns_i    (uns_q),
    .ld_o     (lane_ld),
    .merged_o (lane_merged)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (lsu_req_valid) begin
        if (lsu_misaligned(lsu_req_size, lsu_req_addr[1:0]))  state_d = RESP;
        else if (lsu_req_we && lsu_req_size == LSU_SZ_W)      state_d = WR;
        else                                                  state_d = RD;
      end
      RD:      state_d = CAP;
      CAP:     state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge lsu_clk) begin
    if (!lsu_rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= lsu_req_we;
        uns_q   <= lsu_req_unsigned;
        size_q  <= lsu_req_size;
        addr_q  <= lsu_req_addr;
        data_q  <= lsu_req_wdata;
        err_q   <= lsu_misaligned(lsu_req_size, lsu_req_addr[1:0]);
        rdata_q <= '0;
      end
      if (state_q == CAP) begin
        if (we_q) data_q  <= lane_merged;
        else      rdata_q <= lane_ld;
      end
    end
  end

  // Strobes are gated by reset so a reset landing on WR never writes.
  assign lsu_req_ready = (state_q == IDLE) || !lsu_rst;
  assign lsu_rsp_valid = lsu_rst && (state_q == RESP);
  assign lsu_rsp_err   = lsu_rsp_valid && err_q;
  assign lsu_rsp_rdata = rdata_q;
  assign dm_re         = lsu_rst && (state_q == RD);
  assign dm_we         = lsu_rst && (state_q == WR);
  assign dm_addr       = {2'b00, addr_q[AWIDTH-1:2]};
  assign dm_data_in    = data_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a byte-array reference model and a synchronous memory.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_uns = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, dm_re, dm_we;
  logic [31:0] rsp_rdata, dm_addr, dm_data_in, dm_data_out;

  always #5 clk = ~clk;

  load_store_unit #(.AWIDTH(32), .DWIDTH(32)) dut (
    .lsu_clk(clk), .lsu_rst(rst_n),
    .lsu_req_valid(req_valid), .lsu_req_ready(req_ready), .lsu_req_we(req_we),
    .lsu_req_size(req_size), .lsu_req_unsigned(req_uns), .lsu_req_addr(req_addr),
    .lsu_req_wdata(req_wdata), .lsu_rsp_valid(rsp_valid), .lsu_rsp_rdata(rsp_rdata),
    .lsu_rsp_err(rsp_err), .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_data_in(dm_data_in), .dm_data_out(dm_data_out)
  );

  // data memory: synchronous read, write on edge, plus a bench poke port
  logic [31:0] mem [0:63];
  logic [31:0] mem_rd = '0;
  logic        poke_en = 1'b0;
  logic [5:0]  poke_w = '0;
  logic [31:0] poke_d = '0;
  always @(posedge clk) begin
    if (dm_re)   mem_rd <= mem[dm_addr[5:0]];
    if (dm_we)   mem[dm_addr[5:0]] <= dm_data_in;
    if (poke_en) mem[poke_w] <= poke_d;
  end
  assign dm_data_out = mem_rd;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit we; bit [1:0] size; bit uns; bit [31:0] addr; bit [31:0] wdata; } req_t;
  typedef struct { int acc; int lat; bit err; bit [31:0] rd; } exp_t;

  bit [7:0] ref_b [0:255];
  exp_t     sbq [$];
  exp_t     e;
  int       n_chk = 0, n_fail = 0;
  int       cur_acc = 0, cur_re_cyc = 0, cur_we_cyc = 0, last_acc = 0;
  bit [31:0] cur_waddr = '0, cur_wword = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  // Byte-granular model: access width, alignment, little-endian assembly, extension.
  task automatic ref_do(input req_t r, output bit err, output bit [31:0] rd, output int nb);
    nb  = (r.size == 2'd0) ? 1 : (r.size == 2'd1) ? 2 : 4;
    err = (r.size == 2'd3) || (r.addr % nb != 0);
    rd  = '0;
    if (err) return;
    if (r.we) begin
      for (int i = 0; i < nb; i++) ref_b[r.addr + i] = r.wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < nb; i++) rd[8*i +: 8] = ref_b[r.addr + i];
      if (!r.uns && nb < 4 && rd[8*nb-1])
        for (int i = nb; i < 4; i++) rd[8*i +: 8] = 8'hFF;
    end
  endtask

  function automatic req_t mk(input bit we, input bit [1:0] sz, input bit uns,
                              input bit [31:0] a, input bit [31:0] d);
    req_t r;
    r.we = we; r.size = sz; r.uns = uns; r.addr = a; r.wdata = d;
    return r;
  endfunction

  function automatic req_t rnd_req();
    return mk(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
              32'($urandom_range(0, 255)), $urandom);
  endfunction

  task automatic drive(input req_t r);
    req_valid = 1'b1; req_we = r.we; req_size = r.size; req_uns = r.uns;
    req_addr = r.addr; req_wdata = r.wdata;
  endtask

  // Called and returns at a negedge.
  task automatic poke(input int w, input bit [31:0] d);
    poke_en = 1'b1; poke_w = 6'(w); poke_d = d;
    for (int i = 0; i < 4; i++) ref_b[4*w+i] = d[8*i +: 8];
    @(posedge clk); #1 poke_en = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge where the DUT is idle again.
  task automatic issue(input req_t r, input bit keep, input req_t nxt);
    bit err; bit [31:0] rd; int nb, lat, tmo, busy; exp_t x;
    drive(r);
    ref_do(r, err, rd, nb);
    lat = err ? 1 : !r.we ? 3 : (nb == 4) ? 2 : 4;
    tmo = 0;
    while (!req_ready && tmo < 50) begin @(negedge clk); tmo++; end
    if (tmo >= 50) begin check("accept_timeout", 1, 0); req_valid = 1'b0; return; end
    cur_re_cyc = (!err && !(r.we && nb == 4)) ? 1 : 0;
    cur_we_cyc = (!err && r.we) ? lat - 1 : 0;
    cur_waddr  = r.addr >> 2;
    cur_wword  = ref_word(int'(r.addr >> 2));
    @(posedge clk); #1;
    cur_acc = cyc; last_acc = cyc;
    x.acc = cyc; x.lat = lat; x.err = err; x.rd = rd;
    sbq.push_back(x);
    @(negedge clk);
    if (keep) drive(nxt); else req_valid = 1'b0;
    busy = 0;
    while (!req_ready && busy < 50) begin busy++; @(negedge clk); end
    check("busy_cycles", busy, lat);
    check("rsp_drained", sbq.size(), 0);
  endtask

  // Response monitor and memory-strobe monitor.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sbq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (t=%0t)", $time);
      end else begin
        e = sbq.pop_front();
        check("rsp_cycle", cyc - e.acc + 1, e.lat);
        check("rsp_err", rsp_err, e.err);
        check("rsp_rdata", rsp_rdata, e.rd);
      end
    end
    if (dm_re) check("re_cycle", cyc - cur_acc + 1, cur_re_cyc);
    if (dm_we) begin
      check("we_cycle", cyc - cur_acc + 1, cur_we_cyc);
      check("we_addr", dm_addr, cur_waddr);
      check("we_data", dm_data_in, cur_wword);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r, n;
    int a1;
    @(negedge clk);
    for (int w = 0; w < 64; w++) poke(w, $urandom);
    check("rst_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_re_we", {dm_re, dm_we}, 2'b00);
    check("rst_dm_addr", dm_addr, 32'h0);
    check("rst_dm_data_in", dm_data_in, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // word store then word load
    issue(mk(1, 2'd2, 0, 32'h8, 32'hDEADBEEF), 0, r);
    check("word_store_mem", mem[2], 32'hDEADBEEF);
    issue(mk(0, 2'd2, 0, 32'h8, 32'h0), 0, r);

    // byte store merge and byte loads
    poke(2, 32'h11223344);
    issue(mk(1, 2'd0, 0, 32'h9, 32'hA5), 0, r);
    check("byte_merge_mem", mem[2], 32'h1122A544);
    issue(mk(0, 2'd0, 0, 32'h9, 32'h0), 0, r);
    issue(mk(0, 2'd0, 1, 32'h9, 32'h0), 0, r);

    // half store merge and half loads
    poke(3, 32'h0);
    issue(mk(1, 2'd1, 0, 32'hE, 32'h8001), 0, r);
    check("half_merge_mem", mem[3], 32'h80010000);
    issue(mk(0, 2'd1, 0, 32'hE, 32'h0), 0, r);
    issue(mk(0, 2'd1, 1, 32'hE, 32'h0), 0, r);

    // misaligned / illegal
    issue(mk(0, 2'd2, 0, 32'h6, 32'h0), 0, r);
    issue(mk(1, 2'd1, 0, 32'h3, 32'h1234), 0, r);
    issue(mk(0, 2'd3, 0, 32'h0, 32'h0), 0, r);

    // reset in the middle of a sub-word store
    poke(1, 32'h12345678);
    drive(mk(1, 2'd0, 0, 32'h4, 32'hFF));
    cur_re_cyc = 0; cur_we_cyc = 0;
    @(posedge clk); #1;
    cur_acc = cyc; rst_n = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_ready", req_ready, 1'b1);
      check("midrst_rsp", rsp_valid, 1'b0);
      @(posedge clk);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("postrst_ready", req_ready, 1'b1);
    repeat (5) @(negedge clk);
    check("midrst_mem", mem[1], 32'h12345678);

    // back-to-back with valid held high
    n = mk(1, 2'd2, 0, 32'h4, $urandom);
    issue(mk(0, 2'd2, 0, 32'h0, 32'h0), 1, n);
    a1 = last_acc;
    issue(n, 0, r);
    check("b2b_accept_gap", last_acc - a1, 4);

    // randomized traffic, sometimes back-to-back
    r = rnd_req();
    for (int i = 0; i < 300; i++) begin
      n = rnd_req();
      issue(r, 1'($urandom), n);
      r = n;
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);

    for (int w = 0; w < 64; w++) check("final_mem", mem[w], ref_word(w));
    check("final_queue_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
